morse_key_sequencer: RTL and testbench

//  Turns a single straight-key input into the one-cycle symbol strobes that drive
//  the morse decoder/display datapath: dot, dash, char_space and word_space.

---
 rtl/morse_key_sequencer_if.sv | 32 +++
 rtl/morse_key_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_morse_key_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/morse_key_sequencer_if.sv
// Signal bundle between a straight-key front end and the morse sequencer.
// The master side owns the key and enable inputs. The slave side (the
// sequencer) drives the four symbol strobes and the debounced key level.
interface morse_key_sequencer_if;
    logic key_in;          // raw straight key, 1 = pressed, asynchronous
    logic enable;          // 0 holds the sequencer idle
    logic dot_out;         // one-cycle strobe, dot element
    logic dash_out;        // one-cycle strobe, dash element
    logic char_space_out;  // one-cycle strobe, end of character
    logic word_space_out;  // one-cycle strobe, end of word
    logic key_db;          // debounced key level

    modport master (
        output key_in,
        output enable,
        input  dot_out,
        input  dash_out,
        input  char_space_out,
        input  word_space_out,
        input  key_db
    );

    modport slave (
        input  key_in,
        input  enable,
        output dot_out,
        output dash_out,
        output char_space_out,
        output word_space_out,
        output key_db
    );
endinterface

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer
// Converts a raw straight-key input into one-cycle dot / dash / char_space /
// word_space strobes. The key is synchronised and debounced. Mark and space
// lengths are then measured in units of TICK_DIV clocks. A four-state FSM
// classifies each mark and emits the space strobes as the silence grows.
module morse_key_sequencer #(
    parameter int TICK_DIV   = 12000000,
    parameter int DEBOUNCE   = 50000,
    parameter int DASH_UNITS = 2,
    parameter int CHAR_UNITS = 3,
    parameter int WORD_UNITS = 7,
    parameter int UNIT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    morse_key_sequencer_if.slave  bus
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    localparam logic [PS_W-1:0]   PS_ZERO    = {PS_W{1'b0}};
    localparam logic [PS_W-1:0]   PS_ONE     = PS_W'(1);
    localparam logic [PS_W-1:0]   PS_LAST    = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_ZERO    = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [UNIT_W-1:0] UNIT_ZERO  = {UNIT_W{1'b0}};
    localparam logic [UNIT_W-1:0] UNIT_MAX   = {UNIT_W{1'b1}};
    localparam logic [UNIT_W-1:0] DASH_MIN   = UNIT_W'(DASH_UNITS);
    localparam logic [UNIT_W-1:0] CHAR_LAST  = UNIT_W'(CHAR_UNITS - 1);
    localparam logic [UNIT_W-1:0] WORD_LAST  = UNIT_W'(WORD_UNITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS    = 2'd1,
        ST_GAP      = 2'd2,
        ST_GAP_CHAR = 2'd3
    } state_t;

    // Saturating increment: a very long mark or space parks at the maximum
    // count instead of wrapping, so an endless press still reads as a dash.
    function automatic logic [UNIT_W-1:0] sat_inc(input logic [UNIT_W-1:0] val);
        logic [UNIT_W-1:0] res;
        if (val == UNIT_MAX) begin
            res = UNIT_MAX;
        end else begin
            res = val + UNIT_W'(1);
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic              sync1_r;
    logic              sync2_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic              key_db_r;
    logic              key_db_d_r;
    logic [PS_W-1:0]   presc_r;
    logic [UNIT_W-1:0] units_r;
    state_t            state_r;
    logic              dot_r;
    logic              dash_r;
    logic              char_r;
    logic              word_r;

    // Combinational helpers
    logic              press_s;
    logic              release_s;
    logic              edge_s;
    logic              tick_s;
    state_t            state_nx_s;
    logic              dot_nx_s;
    logic              dash_nx_s;
    logic              char_nx_s;
    logic              word_nx_s;

    // Edge events last one cycle. They mark the start of a new mark or space.
    assign press_s   = key_db_r & ~key_db_d_r;
    assign release_s = ~key_db_r & key_db_d_r;
    assign edge_s    = press_s | release_s;
    assign tick_s    = (presc_r == PS_LAST);

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------

    // Two-flop synchroniser for the asynchronous key pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= bus.key_in;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_r <= DB_ZERO;
            key_db_r <= 1'b0;
        end else if (sync2_r != key_db_r) begin
            if (db_cnt_r == DB_LAST) begin
                db_cnt_r <= DB_ZERO;
                key_db_r <= sync2_r;
            end else begin
                db_cnt_r <= db_cnt_r + DB_ONE;
                key_db_r <= key_db_r;
            end
        end else begin
            db_cnt_r <= DB_ZERO;
            key_db_r <= key_db_r;
        end
    end

    // Delayed copy of the debounced level for press/release edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db_d_r <= 1'b0;
        end else begin
            key_db_d_r <= key_db_r;
        end
    end

    // ------------------------------------------------------------------
    // Timing: prescaler and unit counter
    // ------------------------------------------------------------------

    // Prescaler cycles 0..TICK_DIV-1 and restarts whenever a mark or space begins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= PS_ZERO;
        end else if (!bus.enable || edge_s || tick_s) begin
            presc_r <= PS_ZERO;
        end else begin
            presc_r <= presc_r + PS_ONE;
        end
    end

    // Unit counter measures the current mark or space length in whole units
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            units_r <= UNIT_ZERO;
        end else if (!bus.enable || edge_s) begin
            units_r <= UNIT_ZERO;
        end else if (tick_s) begin
            units_r <= sat_inc(units_r);
        end else begin
            units_r <= units_r;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // Next-state and next-strobe decode. A press always beats a space
    // threshold landing in the same cycle.
    always_comb begin
        state_nx_s = state_r;
        dot_nx_s   = 1'b0;
        dash_nx_s  = 1'b0;
        char_nx_s  = 1'b0;
        word_nx_s  = 1'b0;
        if (!bus.enable) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (press_s) begin
                        state_nx_s = ST_PRESS;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_PRESS: begin
                    if (release_s) begin
                        state_nx_s = ST_GAP;
                        if (units_r >= DASH_MIN) begin
                            dash_nx_s = 1'b1;
                        end else begin
                            dot_nx_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_PRESS;
                    end
                end
                ST_GAP: begin
                    if (press_s) begin
                        state_nx_s = ST_PRESS;
                    end else if (tick_s && (units_r == CHAR_LAST)) begin
                        state_nx_s = ST_GAP_CHAR;
                        char_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_GAP;
                    end
                end
                ST_GAP_CHAR: begin
                    if (press_s) begin
                        state_nx_s = ST_PRESS;
                    end else if (tick_s && (units_r == WORD_LAST)) begin
                        state_nx_s = ST_IDLE;
                        word_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_GAP_CHAR;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered one-cycle strobes. The decode raises at most one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_r  <= 1'b0;
            dash_r <= 1'b0;
            char_r <= 1'b0;
            word_r <= 1'b0;
        end else begin
            dot_r  <= dot_nx_s;
            dash_r <= dash_nx_s;
            char_r <= char_nx_s;
            word_r <= word_nx_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dot_out        = dot_r;
    assign bus.dash_out       = dash_r;
    assign bus.char_space_out = char_r;
    assign bus.word_space_out = word_r;
    assign bus.key_db         = key_db_r;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer. The configuration is
// TICK_DIV=4, DEBOUNCE=2, DASH=2, CHAR=3, WORD=7, UNIT_W=4.
// Latencies in this configuration:
//   - A raw release produces a dot/dash 5 clocks later.
//   - char_space follows the element strobe by 12 clocks.
//   - word_space follows the element strobe by 28 clocks.
module tb_morse_key_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    morse_key_sequencer_if bus ();

    morse_key_sequencer #(
        .TICK_DIV   (4),
        .DEBOUNCE   (2),
        .DASH_UNITS (2),
        .CHAR_UNITS (3),
        .WORD_UNITS (7),
        .UNIT_W     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Cycle counter and strobe monitor (sampled on the falling edge)
    int cyc = 0;
    int n_dot = 0, n_dash = 0, n_char = 0, n_word = 0, n_kdb = 0;
    int t_dot = 0, t_dash = 0, t_char = 0, t_word = 0;
    int n_multi = 0, n_wide = 0;
    logic [3:0] strb;
    logic [3:0] prev_strb = 4'b0000;

    assign strb = {bus.dot_out, bus.dash_out, bus.char_space_out, bus.word_space_out};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dot_out)        begin n_dot  <= n_dot + 1;  t_dot  <= cyc; end
        if (bus.dash_out)       begin n_dash <= n_dash + 1; t_dash <= cyc; end
        if (bus.char_space_out) begin n_char <= n_char + 1; t_char <= cyc; end
        if (bus.word_space_out) begin n_word <= n_word + 1; t_word <= cyc; end
        if (bus.key_db)         n_kdb <= n_kdb + 1;
        if ($countones(strb) > 1) n_multi <= n_multi + 1;
        if ((strb & prev_strb) != 4'b0000) n_wide <= n_wide + 1;
        prev_strb <= strb;
    end

    int s_dot, s_dash, s_char, s_word, s_kdb;
    int rel;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_dot  = n_dot;
        s_dash = n_dash;
        s_char = n_char;
        s_word = n_word;
        s_kdb  = n_kdb;
    endtask

    function automatic int d_all();
        return (n_dot - s_dot) + (n_dash - s_dash) + (n_char - s_char) + (n_word - s_word);
    endfunction

    task automatic pulse_key(input int hold, output int rel_c);
        bus.key_in = 1'b1;
        step(hold);
        bus.key_in = 1'b0;
        rel_c = cyc;
    endtask

    initial begin
        rst        = 1'b1;
        bus.key_in = 1'b0;
        bus.enable = 1'b1;
        step(3);
        // Reset state
        check("rst_key_db", int'(bus.key_db), 0);
        check("rst_dot",    int'(bus.dot_out), 0);
        check("rst_dash",   int'(bus.dash_out), 0);
        check("rst_char",   int'(bus.char_space_out), 0);
        check("rst_word",   int'(bus.word_space_out), 0);
        rst = 1'b0;
        step(5);
        check("idle_quiet", n_dot + n_dash + n_char + n_word, 0);

        // 1. 6-clock press -> dot 5 clocks after the raw release, then the spaces
        snap();
        pulse_key(6, rel);
        step(6);
        check("t1_dot_cnt",  n_dot - s_dot, 1);
        check("t1_dot_lat",  t_dot - rel, 5);
        check("t1_dash_cnt", n_dash - s_dash, 0);
        check("t1_char_early", n_char - s_char, 0);
        step(40);
        check("t1_char_cnt", n_char - s_char, 1);
        check("t1_char_lat", t_char - t_dot, 12);
        check("t1_word_cnt", n_word - s_word, 1);
        check("t1_word_lat", t_word - t_dot, 28);

        // 2. 12-clock press -> dash, char +12, word +28, then silence
        snap();
        pulse_key(12, rel);
        step(6);
        check("t2_dash_cnt", n_dash - s_dash, 1);
        check("t2_dash_lat", t_dash - rel, 5);
        check("t2_dot_cnt",  n_dot - s_dot, 0);
        step(40);
        check("t2_char_lat", t_char - t_dash, 12);
        check("t2_word_lat", t_word - t_dash, 28);
        check("t2_char_cnt", n_char - s_char, 1);
        check("t2_word_cnt", n_word - s_word, 1);
        snap();
        step(20);
        check("t2_silence", d_all(), 0);

        // 3. dot, 6-clock gap, dot -> no char space between them
        snap();
        pulse_key(6, rel);
        step(6);
        pulse_key(6, rel);
        step(6);
        check("t3_dot_cnt",  n_dot - s_dot, 2);
        check("t3_no_char",  n_char - s_char, 0);
        step(40);
        check("t3_char_cnt", n_char - s_char, 1);
        check("t3_word_cnt", n_word - s_word, 1);

        // 3b. press edge lands on the char-space tick -> press wins
        snap();
        pulse_key(6, rel);
        step(12);
        pulse_key(6, rel);
        step(45);
        check("t3b_dot_cnt",  n_dot - s_dot, 2);
        check("t3b_char_cnt", n_char - s_char, 1);
        check("t3b_char_lat", t_char - t_dot, 12);
        check("t3b_word_cnt", n_word - s_word, 1);

        // 4. one-clock glitch is rejected by the debouncer
        snap();
        bus.key_in = 1'b1;
        step(1);
        bus.key_in = 1'b0;
        step(10);
        check("t4_key_db",  n_kdb - s_kdb, 0);
        check("t4_strobes", d_all(), 0);

        // 5. reset mid-press discards the element
        snap();
        bus.key_in = 1'b1;
        step(8);
        check("t5_key_db_hi", int'(bus.key_db), 1);
        rst = 1'b1;
        #1;
        check("t5_key_db_rst", int'(bus.key_db), 0);
        check("t5_strb_rst",   int'(strb), 0);
        step(1);
        rst        = 1'b0;
        bus.key_in = 1'b0;
        step(45);
        check("t5_no_strobe", d_all(), 0);

        // 6. very long press saturates the counter -> one dash
        snap();
        pulse_key(100, rel);
        step(6);
        check("t6_dash_cnt", n_dash - s_dash, 1);
        check("t6_dot_cnt",  n_dot - s_dot, 0);
        step(40);
        check("t6_dash_once", n_dash - s_dash, 1);
        check("t6_word_cnt",  n_word - s_word, 1);

        // 7. enable dropped during the gap -> no spaces until a new press
        snap();
        pulse_key(6, rel);
        step(8);
        check("t7_dot_cnt", n_dot - s_dot, 1);
        bus.enable = 1'b0;
        step(40);
        check("t7_char_off", n_char - s_char, 0);
        check("t7_word_off", n_word - s_word, 0);
        bus.enable = 1'b1;
        step(20);
        check("t7_char_idle", n_char - s_char, 0);
        pulse_key(6, rel);
        step(45);
        check("t7_dot_again", n_dot - s_dot, 2);
        check("t7_char_cnt",  n_char - s_char, 1);
        check("t7_word_cnt",  n_word - s_word, 1);

        // 8. key already held when enable rises -> ignored
        snap();
        bus.enable = 1'b0;
        bus.key_in = 1'b1;
        step(20);
        bus.enable = 1'b1;
        step(20);
        check("t8_key_db", int'(bus.key_db), 1);
        bus.key_in = 1'b0;
        step(45);
        check("t8_no_strobe", d_all(), 0);

        // Global strobe properties
        check("one_hot",  n_multi, 0);
        check("one_wide", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
